// File: rtl/prga_decrypt.sv
// RC4 PRGA / decryption stage.
// Reads a length-prefixed ciphertext from CT RAM. For every byte it performs
// one PRGA step on the S RAM, swapping S[i] and S[j] in place. It writes the
// length-prefixed plaintext to PT RAM.
// Optional build macro: PRGA_ASCII_CHECK_EN. When it is defined, pt_valid
// tracks whether every plaintext byte of the last run was printable ASCII.
//
// Handshake: the block is idle and accepts a start when rdy=1. A start is a
// cycle in which rdy=1 and en=1. rdy drops on the following cycle and rises
// again when the run ends. en is ignored while rdy=0.
//
// All outputs are registered and computed together with the next state.
// The S, CT and PT RAMs return read data one cycle after the address.
// Each PT write cycle also presents the next byte's S[i+1] and CT[k+1] reads.
// Overlapping these steps gives 8 cycles per message byte and 4+8L cycles
// per run.
module prga_decrypt #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_rddata,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [ADDR_W-1:0] ct_addr,
  input  logic [DATA_W-1:0] ct_rddata,
  output logic [ADDR_W-1:0] pt_addr,
  output logic [DATA_W-1:0] pt_wrdata,
  output logic              pt_wren,
  output logic              pt_valid
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_RD,
    ST_LEN_WAIT,
    ST_LEN_WR,
    ST_WAIT_SI,
    ST_RD_SJ,
    ST_WAIT_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_PAD,
    ST_WAIT_PAD,
    ST_WR_PT,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   i_q, i_d;
  logic [ADDR_W-1:0]   j_q, j_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [DATA_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]   si_q, si_d;
  logic [DATA_W-1:0]   sj_q, sj_d;
  logic [DATA_W-1:0]   ctb_q, ctb_d;
  logic                rdy_q, rdy_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wrdata_q, s_wrdata_d;
  logic                s_wren_q, s_wren_d;
  logic [ADDR_W-1:0]   ct_addr_q, ct_addr_d;
  logic [ADDR_W-1:0]   pt_addr_q, pt_addr_d;
  logic [DATA_W-1:0]   pt_wrdata_q, pt_wrdata_d;
  logic                pt_wren_q, pt_wren_d;
  logic [DATA_W-1:0]   pt_byte;

  // In WAIT_PAD, s_rddata is the keystream pad byte S[si+sj].
  assign pt_byte = s_rddata ^ ctb_q;

`ifdef PRGA_ASCII_CHECK_EN
  logic pt_valid_q, pt_valid_d;
  logic pt_byte_bad;
  assign pt_byte_bad = (pt_byte < 8'h20) || (pt_byte > 8'h7E);
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    si_d        = si_q;
    sj_d        = sj_q;
    ctb_d       = ctb_q;
    rdy_d       = rdy_q;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    pt_wren_d   = 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
    pt_valid_d  = pt_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_LEN_RD;
          rdy_d     = 1'b0;
          i_d       = '0;
          j_d       = '0;
          k_d       = '0;
          ct_addr_d = '0;
`ifdef PRGA_ASCII_CHECK_EN
          pt_valid_d = 1'b1;
`endif
        end
      end
      ST_LEN_RD: begin
        state_d = ST_LEN_WAIT;
      end
      ST_LEN_WAIT: begin
        // The length byte is copied to PT[0]. The first byte's S[i+1] and
        // CT[1] reads are issued now in case the length is nonzero.
        len_d       = ct_rddata;
        pt_addr_d   = '0;
        pt_wrdata_d = ct_rddata;
        pt_wren_d   = 1'b1;
        k_d         = ONE_A;
        s_addr_d    = i_q + ONE_A;
        ct_addr_d   = ONE_A;
        state_d     = ST_LEN_WR;
      end
      ST_LEN_WR: begin
        if (len_q == '0) begin
          state_d = ST_DONE;
        end else begin
          i_d     = i_q + ONE_A;
          state_d = ST_WAIT_SI;
        end
      end
      ST_WAIT_SI: begin
        si_d     = s_rddata;
        ctb_d    = ct_rddata;
        j_d      = j_q + s_rddata;
        s_addr_d = j_q + s_rddata;
        state_d  = ST_RD_SJ;
      end
      ST_RD_SJ: begin
        state_d = ST_WAIT_SJ;
      end
      ST_WAIT_SJ: begin
        sj_d       = s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = s_rddata;
        s_wren_d   = 1'b1;
        state_d    = ST_WR_SI;
      end
      ST_WR_SI: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
        state_d    = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        s_addr_d = si_q + sj_q;
        state_d  = ST_RD_PAD;
      end
      ST_RD_PAD: begin
        state_d = ST_WAIT_PAD;
      end
      ST_WAIT_PAD: begin
        // The plaintext write and the next byte's reads go out together.
        // If this is the last byte, those reads are harmless.
        pt_addr_d   = k_q;
        pt_wrdata_d = pt_byte;
        pt_wren_d   = 1'b1;
        s_addr_d    = i_q + ONE_A;
        ct_addr_d   = k_q + ONE_A;
`ifdef PRGA_ASCII_CHECK_EN
        if (pt_byte_bad) pt_valid_d = 1'b0;
`endif
        state_d     = ST_WR_PT;
      end
      ST_WR_PT: begin
        // k is compared with len before the increment, so len=255 ends
        // without k wrapping.
        if (k_q == len_q) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + ONE_A;
          i_d     = i_q + ONE_A;
          state_d = ST_WAIT_SI;
        end
      end
      ST_DONE: begin
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      len_q       <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      ctb_q       <= '0;
      rdy_q       <= 1'b1;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      ctb_q       <= ctb_d;
      rdy_q       <= rdy_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
      pt_wren_q   <= pt_wren_d;
    end
  end

`ifdef PRGA_ASCII_CHECK_EN
  // Printable-plaintext flag. It is set at run start and cleared by any
  // non-printable output byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pt_valid_q <= 1'b1;
    else     pt_valid_q <= pt_valid_d;
  end
  assign pt_valid = pt_valid_q;
`else
  assign pt_valid = 1'b1;
`endif

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt. It provides the S, CT and PT RAMs with one-cycle
// read latency. A plain RC4 reference model predicts every PT write, which
// goes into exp_q. A monitor pops exp_q on each pt_wren and compares.
module tb_prga_decrypt;

  localparam int BUDGET = 3000;

  logic       clk;
  logic       rst;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;
  logic       pt_valid;

  logic [7:0] s_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;

  int ref_s [256];
  int ref_ct [256];
  logic [15:0] exp_q [$];

  int total;
  int bad;
  int s_wr_cnt;

  prga_decrypt dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren),
    .pt_valid(pt_valid)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // RAM models.
  always @(posedge clk) begin
    if (ld_en) s_mem[ld_addr] <= ld_data;
    else if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each PT write with the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_wren) s_wr_cnt++;
      if (pt_wren) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pt_unexpected: got addr=%0h data=%0h with nothing expected", pt_addr, pt_wrdata);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if ({pt_addr, pt_wrdata} != e) begin
            bad++;
            $display("FAIL pt_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                     pt_addr, pt_wrdata, e[15:8], e[7:0]);
          end
        end
      end
    end
  end

  // Reference RC4 PRGA over ref_s. Pushes the expected PT writes and returns
  // whether every plaintext byte is printable.
  task automatic model_run(input int len, output bit printable);
    int i, j, t, pad, pt;
    printable = 1'b1;
    exp_q.push_back({8'h00, len[7:0]});
    i = 0;
    j = 0;
    for (int n = 1; n <= len; n++) begin
      i = (i + 1) % 256;
      j = (j + ref_s[i]) % 256;
      t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
      pad = ref_s[(ref_s[i] + ref_s[j]) % 256];
      pt = ref_ct[n] ^ pad;
      exp_q.push_back({n[7:0], pt[7:0]});
      if (pt < 32 || pt > 126) printable = 1'b0;
    end
  endtask

  function automatic int exp_valid(input bit printable);
`ifdef PRGA_ASCII_CHECK_EN
    return int'(printable);
`else
    return 1;
`endif
  endfunction

  task automatic set_identity();
    for (int x = 0; x < 256; x++) ref_s[x] = x;
  endtask

  task automatic set_shuffled();
    set_identity();
    for (int x = 255; x > 0; x--) begin
      int y, t;
      y = int'($urandom_range(x, 0));
      t = ref_s[x]; ref_s[x] = ref_s[y]; ref_s[y] = t;
    end
  endtask

  // Driver: copy ref_s into the S RAM through the bench load port.
  task automatic load_s();
    for (int x = 0; x < 256; x++) begin
      @(negedge clk);
      ld_en = 1'b1;
      ld_addr = x[7:0];
      ld_data = ref_s[x][7:0];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_ct(input int len);
    ref_ct[0] = len;
    for (int x = 0; x < 256; x++) ct_mem[x] = ref_ct[x][7:0];
  endtask

  // Driver: pulse en, optionally pulse it again mid-run, then wait for rdy.
  task automatic start_and_wait(input int pulse_at, output int cyc);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    cyc = 0;
    while (!rdy && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      en = (cyc == pulse_at);
    end
    en = 1'b0;
    if (cyc >= BUDGET) chk("rdy_timeout", cyc, 0);
  endtask

  task automatic check_s(input string name);
    int first;
    first = -1;
    for (int x = 255; x >= 0; x--) if (int'(s_mem[x]) != ref_s[x]) first = x;
    if (first < 0) chk(name, 0, 0 + first + 1);
    else chk(name, int'(s_mem[first]), ref_s[first]);
  endtask

  task automatic full_run(input string tag, input int len, input int pulse_at);
    bit pr;
    int cyc;
    load_ct(len);
    load_s();
    model_run(len, pr);
    s_wr_cnt = 0;
    start_and_wait(pulse_at, cyc);
    @(negedge clk);
    chk({tag, "_cycles"}, cyc, 4 + 8 * len);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_s_writes"}, s_wr_cnt, 2 * len);
    chk({tag, "_pt_valid"}, int'(pt_valid), exp_valid(pr));
    check_s({tag, "_s_final"});
  endtask

  task automatic set_vec1();
    ref_ct[1] = 'h43; ref_ct[2] = 'h47; ref_ct[3] = 'h44;
  endtask

  // Main sequence.
  initial begin
    total = 0;
    bad = 0;
    s_wr_cnt = 0;
    rst = 1'b1;
    en = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    for (int x = 0; x < 256; x++) begin
      ref_ct[x] = 0;
      ct_mem[x] = '0;
      pt_mem[x] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_rdy", int'(rdy), 1);
    chk("rst_s_wren", int'(s_wren), 0);
    chk("rst_pt_wren", int'(pt_wren), 0);
    chk("rst_addrs", int'({s_addr, ct_addr, pt_addr}), 0);
    chk("rst_wrdata", int'({s_wrdata, pt_wrdata}), 0);
    chk("rst_pt_valid", int'(pt_valid), 1);
    rst = 1'b0;
    @(negedge clk);

    // Known vector with identity S.
    set_identity();
    set_vec1();
    full_run("vec1", 3, 0);
    chk("vec1_pt0", int'(pt_mem[0]), 'h03);
    chk("vec1_pt1", int'(pt_mem[1]), 'h41);
    chk("vec1_pt2", int'(pt_mem[2]), 'h42);
    chk("vec1_pt3", int'(pt_mem[3]), 'h43);
    chk("vec1_s2", int'(s_mem[2]), 'h03);
    chk("vec1_s3", int'(s_mem[3]), 'h05);
    chk("vec1_s5", int'(s_mem[5]), 'h02);

    // The same vector with a stray en pulse mid-run.
    set_identity();
    set_vec1();
    full_run("pulse", 3, 9);

    // Zero-length message.
    set_identity();
    pt_mem[0] = 8'hAA;
    full_run("len0", 0, 0);
    chk("len0_pt0", int'(pt_mem[0]), 0);

    // Reset during the second byte's S[i] write.
    begin
      bit pr;
      int cyc;
      set_identity();
      set_vec1();
      load_ct(3);
      load_s();
      model_run(3, pr);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      cyc = 0;
      while (cyc < 14) begin
        @(negedge clk);
        cyc++;
      end
      chk("pre_rst_s_wren", int'(s_wren), 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_rdy", int'(rdy), 1);
      chk("arst_s_wren", int'(s_wren), 0);
      chk("arst_pt_wren", int'(pt_wren), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      set_identity();
      set_vec1();
      full_run("after_rst", 3, 0);
    end

    // en held high: a second run starts right after the first and uses the S
    // left by the first.
    begin
      bit pr1, pr2;
      int cyc, len;
      len = int'($urandom_range(12, 2));
      set_shuffled();
      for (int n = 1; n <= len; n++) ref_ct[n] = int'($urandom_range(255, 0));
      load_ct(len);
      load_s();
      model_run(len, pr1);
      model_run(len, pr2);
      s_wr_cnt = 0;
      en = 1'b1;
      @(negedge clk);
      cyc = 0;
      while (!rdy && cyc < BUDGET) begin
        @(negedge clk);
        cyc++;
      end
      chk("hold_cycles1", cyc, 4 + 8 * len);
      @(negedge clk);
      chk("hold_restart_rdy", int'(rdy), 0);
      en = 1'b0;
      cyc = 0;
      while (!rdy && cyc < BUDGET) begin
        @(negedge clk);
        cyc++;
      end
      @(negedge clk);
      chk("hold_cycles2", cyc, 4 + 8 * len);
      chk("hold_drain", exp_q.size(), 0);
      chk("hold_s_writes", s_wr_cnt, 4 * len);
      chk("hold_pt_valid", int'(pt_valid), exp_valid(pr2));
      check_s("hold_s_final");
    end

    // Short non-printable vector: identity S, CT={01,03}.
    set_identity();
    ref_ct[1] = 'h03;
    full_run("ascii_bad", 1, 0);
    chk("ascii_bad_pt1", int'(pt_mem[1]), 'h01);

    // Random keys and messages, including the longest message.
    for (int r = 0; r < 6; r++) begin
      int len;
      len = (r == 5) ? 255 : int'($urandom_range(40, 1));
      set_shuffled();
      for (int n = 1; n <= len; n++) ref_ct[n] = int'($urandom_range(255, 0));
      full_run("rand", len, (r == 2) ? 20 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
